// File: rtl/menu_controller_if.sv
// Button/tick inputs and menu display values shared between the push-button
// board logic and the VGA menu overlay.
interface menu_controller_if;
  logic       btn_next;
  logic       btn_prev;
  logic       btn_up;
  logic       btn_down;
  logic       minute_tick;
  logic [3:0] state;
  logic [11:0] set_temp;
  logic [7:0] set_hum;
  logic [4:0] time_hours;
  logic [5:0] time_minutes;
  logic [4:0] sunrise_hours;
  logic [5:0] sunrise_minutes;
  logic       sunrise_pulse;

  modport master (
    output btn_next, btn_prev, btn_up, btn_down, minute_tick,
    input  state, set_temp, set_hum, time_hours, time_minutes,
           sunrise_hours, sunrise_minutes, sunrise_pulse
  );

  modport slave (
    input  btn_next, btn_prev, btn_up, btn_down, minute_tick,
    output state, set_temp, set_hum, time_hours, time_minutes,
           sunrise_hours, sunrise_minutes, sunrise_pulse
  );
endinterface

// File: rtl/menu_controller.sv
// Button-driven menu sequencer: debounced next/prev/up/down edit the menu fields,
// minute_tick runs the clock. Define MENU_TIMEOUT_EN to return to field 0 after idling.
module menu_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_DELAY    = 12500000,
  parameter int unsigned REPEAT_PERIOD   = 2500000,
  parameter int unsigned TEMP_MIN        = 500,
  parameter int unsigned TEMP_MAX        = 1000,
  parameter int unsigned TEMP_STEP       = 5,
  parameter int unsigned TEMP_DEFAULT    = 720,
  parameter int unsigned HUM_MAX         = 100,
  parameter int unsigned TIMEOUT_CYCLES  = 250000000
) (
  input  logic               clk,
  input  logic               rst,
  menu_controller_if.slave   bus
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W = $clog2(REP_MAX + 1);

  typedef enum logic [3:0] {
    F_TEMP = 4'd0, F_HUM = 4'd1, F_THR = 4'd2, F_TMIN = 4'd3, F_SHR = 4'd4, F_SMIN = 4'd5
  } field_e;

  // Button index: 0 next, 1 prev, 2 up, 3 down
  logic [3:0]       raw, sync1, sync2, deb, deb_q, rise;
  logic [DB_W-1:0]  db_cnt [4];
  logic [REP_W-1:0] rep_cnt [2];
  logic [1:0]       rep_mode, rep_fire;
  logic             act_next, act_prev, act_up, act_down, edit, tick_apply;

  field_e      field, field_n;
  logic [11:0] temp, temp_n;
  logic [7:0]  hum, hum_n;
  logic [4:0]  hours, hours_n, sr_hours, sr_hours_n;
  logic [5:0]  mins, mins_n, sr_mins, sr_mins_n;
  logic        pulse, pulse_n;

`ifdef MENU_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
`endif

  function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] top,
                                           input logic up);
    if (up) return (v == top) ? 6'd0 : v + 6'd1;
    return (v == 6'd0) ? top : v - 6'd1;
  endfunction

  assign raw  = {bus.btn_down, bus.btn_up, bus.btn_prev, bus.btn_next};
  assign rise = deb & ~deb_q;

  // Action decode: one action per cycle, next > prev > up > down
  always_comb begin
    rep_fire = '0;
    for (int i = 0; i < 2; i++) begin
      rep_fire[i] = deb[i+2] && deb_q[i+2] &&
                    (rep_cnt[i] == (rep_mode[i] ? REP_W'(REPEAT_PERIOD) : REP_W'(REPEAT_DELAY)));
    end
    act_next = rise[0];
    act_prev = !rise[0] && rise[1];
    act_up   = !rise[0] && !rise[1] && (rise[2] || rep_fire[0]);
    act_down = !rise[0] && !rise[1] && !act_up && (rise[3] || rep_fire[1]);
    edit     = act_up || act_down;
  end

  always_comb begin
    field_n    = field;
    temp_n     = temp;
    hum_n      = hum;
    hours_n    = hours;
    mins_n     = mins;
    sr_hours_n = sr_hours;
    sr_mins_n  = sr_mins;
    if (act_next) begin
      field_n = (field == F_SMIN) ? F_TEMP : field_e'(field + 4'd1);
    end else if (act_prev) begin
      field_n = (field == F_TEMP) ? F_SMIN : field_e'(field - 4'd1);
    end else if (edit) begin
      case (field)
        F_TEMP: begin
          if (act_up)
            temp_n = (temp >= 12'(TEMP_MAX - TEMP_STEP)) ? 12'(TEMP_MAX) : temp + 12'(TEMP_STEP);
          else
            temp_n = (temp <= 12'(TEMP_MIN + TEMP_STEP)) ? 12'(TEMP_MIN) : temp - 12'(TEMP_STEP);
        end
        F_HUM: begin
          if (act_up) hum_n = (hum >= 8'(HUM_MAX)) ? 8'(HUM_MAX) : hum + 8'd1;
          else        hum_n = (hum == 8'd0) ? 8'd0 : hum - 8'd1;
        end
        F_THR:  hours_n    = 5'(wrap_step(6'(hours), 6'd23, act_up));
        F_TMIN: mins_n     = wrap_step(mins, 6'd59, act_up);
        F_SHR:  sr_hours_n = 5'(wrap_step(6'(sr_hours), 6'd23, act_up));
        F_SMIN: sr_mins_n  = wrap_step(sr_mins, 6'd59, act_up);
        default: ;
      endcase
    end
    // An edit of the running time wins over a coincident tick
    tick_apply = bus.minute_tick && !(edit && (field == F_THR || field == F_TMIN));
    if (tick_apply) begin
      mins_n = (mins == 6'd59) ? 6'd0 : mins + 6'd1;
      if (mins == 6'd59) hours_n = (hours == 5'd23) ? 5'd0 : hours + 5'd1;
    end
    pulse_n = tick_apply && (hours_n == sr_hours_n) && (mins_n == sr_mins_n);
`ifdef MENU_TIMEOUT_EN
    if (!(act_next || act_prev || edit) && to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) field_n = F_TEMP;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      deb      <= '0;
      deb_q    <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
      for (int i = 0; i < 2; i++) rep_cnt[i] <= '0;
      rep_mode <= '0;
      field    <= F_TEMP;
      temp     <= 12'(TEMP_DEFAULT);
      hum      <= 8'd50;
      hours    <= 5'd12;
      mins     <= 6'd0;
      sr_hours <= 5'd6;
      sr_mins  <= 6'd30;
      pulse    <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] != deb[i]) begin
          if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            deb[i]    <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DB_W'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
      // Hold counters measure cycles since the last up/down action
      for (int i = 0; i < 2; i++) begin
        if (!deb[i+2]) begin
          rep_cnt[i]  <= '0;
          rep_mode[i] <= 1'b0;
        end else if (rise[i+2]) begin
          rep_cnt[i]  <= REP_W'(1);
          rep_mode[i] <= 1'b0;
        end else if (rep_fire[i]) begin
          rep_cnt[i]  <= REP_W'(1);
          rep_mode[i] <= 1'b1;
        end else begin
          rep_cnt[i]  <= rep_cnt[i] + REP_W'(1);
        end
      end
      field    <= field_n;
      temp     <= temp_n;
      hum      <= hum_n;
      hours    <= hours_n;
      mins     <= mins_n;
      sr_hours <= sr_hours_n;
      sr_mins  <= sr_mins_n;
      pulse    <= pulse_n;
    end
  end

`ifdef MENU_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    to_cnt <= '0;
    else if (act_next || act_prev || edit)      to_cnt <= '0;
    else if (to_cnt != TO_W'(TIMEOUT_CYCLES))   to_cnt <= to_cnt + TO_W'(1);
  end
`endif

  assign bus.state           = field;
  assign bus.set_temp        = temp;
  assign bus.set_hum         = hum;
  assign bus.time_hours      = hours;
  assign bus.time_minutes    = mins;
  assign bus.sunrise_hours   = sr_hours;
  assign bus.sunrise_minutes = sr_mins;
  assign bus.sunrise_pulse   = pulse;

endmodule

// File: tb/tb_menu_controller.sv
// Directed bench for menu_controller with short debounce/repeat timing.
module tb_menu_controller;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   pulse_cnt = 0;

  menu_controller_if bus();

  menu_controller #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.sunrise_pulse) pulse_cnt <= pulse_cnt + 1;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      0: bus.btn_next = v;
      1: bus.btn_prev = v;
      2: bus.btn_up   = v;
      default: bus.btn_down = v;
    endcase
  endtask

  task automatic press(input int idx, input int hold);
    set_btn(idx, 1'b1);
    cyc(hold);
    set_btn(idx, 1'b0);
    cyc(12);
  endtask

  task automatic tick();
    bus.minute_tick = 1'b1;
    cyc(1);
    bus.minute_tick = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.btn_next = 0; bus.btn_prev = 0; bus.btn_up = 0; bus.btn_down = 0;
    bus.minute_tick = 0;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    chk("rst_state", bus.state, 0);
    chk("rst_temp", bus.set_temp, 720);
    chk("rst_hum", bus.set_hum, 50);
    chk("rst_hr", bus.time_hours, 12);
    chk("rst_min", bus.time_minutes, 0);
    chk("rst_srh", bus.sunrise_hours, 6);
    chk("rst_srm", bus.sunrise_minutes, 30);
    chk("rst_pulse", bus.sunrise_pulse, 0);

    // Glitch rejected, then debounced press with exact latency
    bus.btn_next = 1; cyc(2); bus.btn_next = 0; cyc(12);
    chk("glitch", bus.state, 0);
    bus.btn_next = 1; cyc(6);
    chk("next_lat0", bus.state, 0);
    cyc(1);
    chk("next_lat1", bus.state, 1);
    cyc(3); bus.btn_next = 0; cyc(12);
    chk("next_once", bus.state, 1);
    press(1, 10); chk("prev", bus.state, 0);
    press(1, 10); chk("prev_wrap", bus.state, 5);
    press(0, 10); chk("next_wrap", bus.state, 0);

    // Temperature auto-repeat and clamping
    bus.btn_up = 1; cyc(7);
    chk("temp_first", bus.set_temp, 725);
    cyc(19); chk("temp_wait", bus.set_temp, 725);
    cyc(1);  chk("temp_rep1", bus.set_temp, 730);
    cyc(5);  chk("temp_rep2", bus.set_temp, 735);
    cyc(400); bus.btn_up = 0; cyc(12);
    chk("temp_max", bus.set_temp, 1000);
    press(3, 10); chk("temp_dn", bus.set_temp, 995);
    press(2, 10); chk("temp_up", bus.set_temp, 1000);
    press(2, 10); chk("temp_clamp", bus.set_temp, 1000);
    press(3, 600); chk("temp_min", bus.set_temp, 500);
    press(2, 10); chk("temp_min_up", bus.set_temp, 505);

    // Humidity
    press(0, 10); chk("st_hum", bus.state, 1);
    press(2, 10); chk("hum_up", bus.set_hum, 51);
    press(3, 10); press(3, 10); chk("hum_dn2", bus.set_hum, 49);
    press(2, 300); chk("hum_max", bus.set_hum, 100);
    press(3, 600); chk("hum_min", bus.set_hum, 0);

    // Minute edits wrap without carry; ticks carry
    press(0, 10); press(0, 10); chk("st_min", bus.state, 3);
    press(3, 10);
    chk("min_dn_wrap", bus.time_minutes, 59); chk("min_dn_hr", bus.time_hours, 12);
    press(2, 10);
    chk("min_up_wrap", bus.time_minutes, 0); chk("min_up_hr", bus.time_hours, 12);
    for (int k = 0; k < 719; k++) tick();
    chk("t2359_hr", bus.time_hours, 23); chk("t2359_min", bus.time_minutes, 59);
    tick();
    chk("t0000_hr", bus.time_hours, 0); chk("t0000_min", bus.time_minutes, 0);

    // Sunrise match
    for (int k = 0; k < 389; k++) tick();
    chk("t0629_hr", bus.time_hours, 6); chk("t0629_min", bus.time_minutes, 29);
    chk("no_early_pulse", pulse_cnt, 0);
    bus.minute_tick = 1; cyc(1); bus.minute_tick = 0;
    chk("t0630_min", bus.time_minutes, 30);
    chk("pulse_hi", bus.sunrise_pulse, 1);
    cyc(1);
    chk("pulse_lo", bus.sunrise_pulse, 0);
    chk("pulse_cnt", pulse_cnt, 1);

    // Edit beats tick on time fields; next beats up
    for (int k = 0; k < 225; k++) tick();
    press(1, 10); chk("st_hr", bus.state, 2);
    chk("t1015_hr", bus.time_hours, 10); chk("t1015_min", bus.time_minutes, 15);
    bus.btn_up = 1; cyc(6);
    bus.minute_tick = 1; cyc(1); bus.minute_tick = 0;
    chk("edit_tick_hr", bus.time_hours, 11); chk("edit_tick_min", bus.time_minutes, 15);
    cyc(3); bus.btn_up = 0; cyc(12);
    bus.btn_next = 1; bus.btn_up = 1; cyc(10);
    bus.btn_next = 0; bus.btn_up = 0; cyc(12);
    chk("nu_state", bus.state, 3);
    chk("nu_hr", bus.time_hours, 11); chk("nu_min", bus.time_minutes, 15);

    // Sunrise edits, idle behaviour, reset mid-hold
    press(0, 10); chk("st_srh", bus.state, 4);
    press(2, 10); chk("srh_up", bus.sunrise_hours, 7);
    press(3, 10); chk("srh_dn", bus.sunrise_hours, 6);
    cyc(60);
`ifdef MENU_TIMEOUT_EN
    chk("idle_state", bus.state, 0);
`else
    chk("idle_state", bus.state, 4);
`endif
    bus.btn_up = 1; cyc(30);
    rst = 1'b1; #1;
    chk("arst_state", bus.state, 0);
    chk("arst_temp", bus.set_temp, 720);
    chk("arst_hum", bus.set_hum, 50);
    chk("arst_hr", bus.time_hours, 12);
    chk("arst_srh", bus.sunrise_hours, 6);
    cyc(1);
    rst = 1'b0; bus.btn_up = 0; cyc(12);
    chk("post_rst_temp", bus.set_temp, 720);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
